// File: rtl/str2int.sv
// ---------------------------------------------------------------------------
// str2int : serial ASCII-decimal string to unsigned binary converter.
// One digit is consumed per clock, most significant digit first. Invalid
// characters and overflow raise a sticky error; overflow saturates the result.
// ---------------------------------------------------------------------------
module str2int #(
  parameter int pBitWidth = 16,
  parameter int pDigits   = 5
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic [8*pDigits-1:0]   iString,
  input  logic                   iStart,
  output logic [pBitWidth-1:0]   oBinary,
  output logic                   oDone,
  output logic                   oBusy,
  output logic                   oError
);

  localparam int CW = $clog2(pDigits + 1);
  localparam int EW = pBitWidth + 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(pDigits - 1);
  localparam logic [EW-1:0] MAX_VAL  = {4'b0000, {pBitWidth{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [8*pDigits-1:0]   r_shift;
  logic [pBitWidth-1:0]   r_acc;
  logic [CW-1:0]          r_cnt;
  logic                   r_err;
  logic                   r_ovf;

  logic [7:0]             w_byte;
  logic                   w_valid;
  logic [3:0]             w_digit;
  logic [EW-1:0]          w_acc_ext;
  logic [EW-1:0]          w_sum;
  logic [pBitWidth-1:0]   w_acc_next;
  logic                   w_ovf_next;
  logic                   w_err_next;

  // True for the ASCII characters '0'..'9'.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Numeric value of an ASCII digit (only meaningful when is_digit holds).
  function automatic logic [3:0] digit_val(input logic [7:0] b);
    logic [7:0] d;
    d = b - 8'h30;
    return d[3:0];
  endfunction

  // Next accumulator value: acc*10 + digit at extended width, then saturate.
  always_comb begin
    w_byte    = r_shift[8*pDigits-1 -: 8];
    w_valid   = is_digit(w_byte);
    if (w_valid) begin
      w_digit = digit_val(w_byte);
    end else begin
      w_digit = 4'd0;
    end
    w_acc_ext = {4'b0000, r_acc};
    w_sum     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{pBitWidth{1'b0}}, w_digit};
    // Once saturated, the value stays clamped for the rest of the string.
    if (r_ovf || (w_sum > MAX_VAL)) begin
      w_acc_next = {pBitWidth{1'b1}};
      w_ovf_next = 1'b1;
    end else begin
      w_acc_next = w_sum[pBitWidth-1:0];
      w_ovf_next = 1'b0;
    end
    w_err_next = r_err | ~w_valid | w_ovf_next;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      oBinary <= '0;
      oDone   <= 1'b0;
      oBusy   <= 1'b0;
      oError  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            r_shift <= iString;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            oBusy   <= 1'b1;
            r_state <= CONV;
          end else begin
            oBusy   <= 1'b0;
          end
        end
        CONV: begin
          r_acc   <= w_acc_next;
          r_err   <= w_err_next;
          r_ovf   <= w_ovf_next;
          r_shift <= {r_shift[8*pDigits-9:0], 8'h00};
          if (r_cnt == LAST_CNT) begin
            oBinary <= w_acc_next;
            oError  <= w_err_next;
            oDone   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          oDone   <= 1'b0;
          oBusy   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          oDone   <= 1'b0;
          oBusy   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
